// File: rtl/houghlines_accel_hls_deadlock_report_ctrl.sv
// Deadlock report controller: debounces unit detections, elects an origin, traces the token loop
// and holds a report until acknowledged. Optional cycle stamp: HOUGHLINES_ACCEL_HLS_DL_CYCLE_CNT_EN.
module houghlines_accel_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TRACE_TIMEOUT   = 1024,
  parameter int CNT_W           = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_seen_vec,
  output logic                dl_detect_bcast,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                report_valid,
  input  logic                report_ack,
  output logic [PROC_NUM-1:0] report_origin,
  output logic [PROC_NUM-1:0] report_loop_mask,
  output logic                report_timeout,
  output logic [CNT_W-1:0]    report_cycle
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = $clog2(TRACE_TIMEOUT);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TRACE_LAST = TW'(TRACE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ORIGIN,
    S_TRACE,
    S_HOLD
  } state_t;

  state_t              state;
  logic [DW-1:0]       deb_cnt;
  logic [TW-1:0]       trace_cnt;
  logic [PROC_NUM-1:0] origin_mask;
  logic [PROC_NUM-1:0] loop_mask;
  logic [PROC_NUM-1:0] lowest_bit;
  logic                close_c;
  logic                tmo_c;

  // Two's-complement trick isolates the lowest-index detecting process.
  assign lowest_bit = dl_detect_vec & (~dl_detect_vec + PROC_NUM'(1));

  // The origin re-raising its detect closes the loop; this must clear tokens in the same cycle.
  assign close_c     = (state == S_TRACE) && (trace_cnt != '0) && (|(dl_detect_vec & origin_mask));
  assign tmo_c       = (state == S_TRACE) && (trace_cnt == TRACE_LAST) && !close_c;
  assign token_clear = close_c | tmo_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      deb_cnt          <= '0;
      trace_cnt        <= '0;
      origin_mask      <= '0;
      loop_mask        <= '0;
      dl_detect_bcast  <= 1'b0;
      origin_vec       <= '0;
      report_valid     <= 1'b0;
      report_origin    <= '0;
      report_loop_mask <= '0;
      report_timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|dl_detect_vec) begin
            state   <= S_DEBOUNCE;
            deb_cnt <= '0;
          end
        end
        S_DEBOUNCE: begin
          if (dl_detect_vec == '0) begin
            state <= S_IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state           <= S_ORIGIN;
            origin_mask     <= lowest_bit;
            origin_vec      <= lowest_bit;
            dl_detect_bcast <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        S_ORIGIN: begin
          state      <= S_TRACE;
          origin_vec <= '0;
          loop_mask  <= origin_mask;
          trace_cnt  <= '0;
        end
        S_TRACE: begin
          loop_mask <= loop_mask | token_seen_vec;
          if (token_clear) begin
            state            <= S_HOLD;
            dl_detect_bcast  <= 1'b0;
            report_valid     <= 1'b1;
            report_origin    <= origin_mask;
            report_loop_mask <= loop_mask | token_seen_vec;
            report_timeout   <= tmo_c;
          end else begin
            trace_cnt <= trace_cnt + TW'(1);
          end
        end
        S_HOLD: begin
          if (report_ack) begin
            state        <= S_IDLE;
            report_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HOUGHLINES_ACCEL_HLS_DL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] origin_cyc;

  // Stamp is taken in the ORIGIN cycle but only published when the report becomes valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_cnt      <= '0;
      origin_cyc   <= '0;
      report_cycle <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (state == S_ORIGIN) origin_cyc <= cyc_cnt;
      if (token_clear) report_cycle <= origin_cyc;
    end
  end
`else
  assign report_cycle = '0;
`endif

endmodule

// File: tb/tb_houghlines_accel_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller: debounce reject, loop close, timeout,
// report handshake and reset mid-trace, with a report scoreboard.
module tb_houghlines_accel_hls_deadlock_report_ctrl;

  localparam int PN  = 4;
  localparam int CW  = 32;
  localparam int DEB = 16;
  localparam int TMO = 8;

  logic          clock;
  logic          reset;
  logic [PN-1:0] dl_detect_vec;
  logic [PN-1:0] token_seen_vec;
  logic          dl_detect_bcast;
  logic [PN-1:0] origin_vec;
  logic          token_clear;
  logic          report_valid;
  logic          report_ack;
  logic [PN-1:0] report_origin;
  logic [PN-1:0] report_loop_mask;
  logic          report_timeout;
  logic [CW-1:0] report_cycle;

  houghlines_accel_hls_deadlock_report_ctrl #(
    .PROC_NUM(PN), .DEBOUNCE_CYCLES(DEB), .TRACE_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .dl_detect_vec(dl_detect_vec), .token_seen_vec(token_seen_vec),
    .dl_detect_bcast(dl_detect_bcast), .origin_vec(origin_vec), .token_clear(token_clear),
    .report_valid(report_valid), .report_ack(report_ack),
    .report_origin(report_origin), .report_loop_mask(report_loop_mask),
    .report_timeout(report_timeout), .report_cycle(report_cycle)
  );

  // clock / reset-relative cycle reference
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [CW-1:0] bench_cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) bench_cyc <= '0;
    else       bench_cyc <= bench_cyc + CW'(1);
  end

  // scoreboard: {origin, loop_mask, timeout} plus the expected cycle stamp
  logic [2*PN:0] exp_q[$];
  logic [CW-1:0] cyc_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_report(input logic [PN-1:0] o, input logic [PN-1:0] l, input logic t);
    exp_q.push_back({o, l, t});
`ifdef HOUGHLINES_ACCEL_HLS_DL_CYCLE_CNT_EN
    cyc_q.push_back(bench_cyc);
`else
    cyc_q.push_back('0);
`endif
  endtask

  task automatic sb_check(input string tag);
    logic [2*PN:0] e;
    logic [CW-1:0] c;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed=report expected=no pending report", tag);
    end else begin
      e = exp_q.pop_front();
      c = cyc_q.pop_front();
      check({tag, "_report"}, {report_origin, report_loop_mask, report_timeout}, e);
      check({tag, "_cycle"}, report_cycle, c);
    end
  endtask

  task automatic ack_pulse();
    report_ack = 1'b1;
    tick();
    report_ack = 1'b0;
  endtask

  // Runs IDLE->ORIGIN with dl held; returns in the ORIGIN cycle.
  task automatic run_debounce(input logic [PN-1:0] dl, output logic early);
    early = 1'b0;
    dl_detect_vec = dl;
    for (int i = 1; i <= DEB; i++) begin
      tick();
      if (origin_vec != '0 || report_valid) early = 1'b1;
    end
    tick();
  endtask

  logic early;
  logic bad;
  logic [63:0] snap;

  initial begin
    reset = 1'b1; dl_detect_vec = '0; token_seen_vec = '0; report_ack = 1'b0;
    repeat (3) tick();
    check("rst_bcast", dl_detect_bcast, 0);
    check("rst_origin_vec", origin_vec, 0);
    check("rst_token_clear", token_clear, 0);
    check("rst_report", {report_valid, report_origin, report_loop_mask, report_timeout}, 0);
    check("rst_cycle", report_cycle, 0);
    reset = 1'b0;

    // debounce reject: 10 cycles of detection then release
    bad = 1'b0;
    dl_detect_vec = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      token_seen_vec = PN'($urandom_range(0, 15));
      tick();
      if (origin_vec != '0 || report_valid || dl_detect_bcast) bad = 1'b1;
    end
    dl_detect_vec = '0;
    for (int i = 0; i < 30; i++) begin
      token_seen_vec = PN'($urandom_range(0, 15));
      tick();
      if (origin_vec != '0 || report_valid || dl_detect_bcast) bad = 1'b1;
    end
    check("deb_reject", bad, 0);
    token_seen_vec = '0;

    // loop close: origin is the lowest of 0110
    run_debounce(4'b0110, early);
    check("lc_no_early_origin", early, 0);
    check("lc_origin_vec", origin_vec, 4'b0010);
    check("lc_bcast_origin", dl_detect_bcast, 1);
    push_report(4'b0010, 4'b1110, 1'b0);
    dl_detect_vec = 4'b0100;
    tick();
    check("lc_origin_pulse_end", origin_vec, 0);
    check("lc_bcast_trace", dl_detect_bcast, 1);
    check("lc_tc_t0", token_clear, 0);
    tick();
    #1 check("lc_tc_t1", token_clear, 0);
    tick(); token_seen_vec = 4'b0100;
    tick(); token_seen_vec = 4'b1000;
    tick(); token_seen_vec = 4'b0000;
    #1 check("lc_tc_t4", token_clear, 0);
    tick(); dl_detect_vec = 4'b0110;
    #1 check("lc_tc_close", token_clear, 1);
    check("lc_valid_before", report_valid, 0);
    tick();
    check("lc_valid", report_valid, 1);
    check("lc_bcast_hold", dl_detect_bcast, 0);
    check("lc_tc_hold", token_clear, 0);
    sb_check("lc");

    // handshake: report must stay put without ack, inputs randomised
    snap = {report_origin, report_loop_mask, report_timeout, report_cycle};
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dl_detect_vec  = PN'($urandom_range(0, 15));
      token_seen_vec = PN'($urandom_range(0, 15));
      tick();
      if (!report_valid || dl_detect_bcast ||
          {report_origin, report_loop_mask, report_timeout, report_cycle} != snap) bad = 1'b1;
    end
    check("hs_hold_stable", bad, 0);
    dl_detect_vec = '0; token_seen_vec = '0;
    ack_pulse();
    check("hs_valid_cleared", report_valid, 0);
    check("hs_data_kept", {report_origin, report_loop_mask, report_timeout}, {4'b0010, 4'b1110, 1'b0});
    report_ack = 1'b1;
    repeat (5) tick();
    report_ack = 1'b0;
    check("hs_idle_ack", {report_valid, dl_detect_bcast, origin_vec}, 0);

    // timeout: origin bit 2 stays low through the trace
    run_debounce(4'b1100, early);
    check("to_no_early_origin", early, 0);
    check("to_origin_vec", origin_vec, 4'b0100);
    push_report(4'b0100, 4'b0101, 1'b1);
    dl_detect_vec = 4'b1000;
    bad = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      tick();
      token_seen_vec = (k == 4) ? 4'b0001 : 4'b0000;
      #1;
      if (k < TMO - 1 && token_clear) bad = 1'b1;
    end
    check("to_tc_early", bad, 0);
    check("to_tc_last", token_clear, 1);
    tick();
    token_seen_vec = '0;
    check("to_valid", report_valid, 1);
    sb_check("to");
    ack_pulse();
    check("to_ack", report_valid, 0);

    // reset in trace cycle 3
    run_debounce(4'b0011, early);
    check("rs_origin_vec", origin_vec, 4'b0001);
    dl_detect_vec = '0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("rs_outputs", {dl_detect_bcast, origin_vec, token_clear, report_valid,
                         report_origin, report_loop_mask, report_timeout}, 0);
    check("rs_cycle", report_cycle, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("rs_idle", {dl_detect_bcast, report_valid, origin_vec}, 0);

    // fresh report after reset; stamp counts from the release edge
    run_debounce(4'b0001, early);
    check("rs2_origin_vec", origin_vec, 4'b0001);
    push_report(4'b0001, 4'b0001, 1'b0);
    dl_detect_vec = '0;
    repeat (3) tick();
    dl_detect_vec = 4'b0001;
    #1 check("rs2_tc_close", token_clear, 1);
    tick();
    check("rs2_valid", report_valid, 1);
    sb_check("rs2");
    dl_detect_vec = '0;
    ack_pulse();
    check("rs2_ack", report_valid, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
